// File: rtl/load_store_unit_if.sv
// Signal bundle between the MEM stage, the load/store unit and DataMemory.
// The master view belongs to the load/store unit. The slave view belongs to the
// environment: the pipeline request side together with the memory.
interface load_store_unit_if;
  // Pipeline request / response
  logic        cpuReq;
  logic        cpuWrite;
  logic [1:0]  cpuMode;
  logic        cpuSigned;
  logic [31:0] cpuAddr;
  logic [31:0] cpuWData;
  logic        cpuReady;
  logic        cpuDone;
  logic        cpuFault;
  logic [31:0] cpuRData;

  // Data-memory bus
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic [1:0]  memMode;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memReadData;
  logic        memReady;

  modport master (
    input  cpuReq, cpuWrite, cpuMode, cpuSigned, cpuAddr, cpuWData,
    output cpuReady, cpuDone, cpuFault, cpuRData,
    output memAddr, memWriteData, memMode, memRead, memWrite,
    input  memReadData, memReady
  );

  modport slave (
    output cpuReq, cpuWrite, cpuMode, cpuSigned, cpuAddr, cpuWData,
    input  cpuReady, cpuDone, cpuFault, cpuRData,
    input  memAddr, memWriteData, memMode, memRead, memWrite,
    output memReadData, memReady
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the data-memory interface.
// Accepts one request while idle and checks its alignment. It then holds the
// memory strobes until memReady arrives or the timeout expires. Completion is
// reported with a one-cycle cpuDone pulse, and load data is zero- or
// sign-extended. Every output comes straight from a register.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16  // REQ cycles without memReady before fault (1..255)
) (
  input logic               clk,
  input logic               rst_n,
  load_store_unit_if.master bus
);

  // Access-size codes shared with DataMemory.
  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  localparam int unsigned     CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LIMIT = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_FAULT
  } state_e;

  // Unsupported mode codes are treated like misaligned accesses.
  function automatic logic misaligned(input logic [1:0] mode, input logic [1:0] lsb);
    case (mode)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return lsb[0];
      MEM_WORD: return lsb != 2'b00;
      default:  return 1'b1;
    endcase
  endfunction

  // Right-aligned raw read data extended to 32 bits according to size and signedness.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  mode,
                                              input logic        sgn);
    case (mode)
      MEM_BYTE: return {{24{sgn & raw[7]}},  raw[7:0]};
      MEM_HALF: return {{16{sgn & raw[15]}}, raw[15:0]};
      default:  return raw;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    mode_q, mode_d;
  logic          signed_q, signed_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          fault_q, fault_d;
  logic [31:0]   rdata_q, rdata_d;

  // The counter never exceeds TIMEOUT, so this increment cannot wrap.
  assign cnt_inc = cnt_q + CW'(1);

  // Next state, plus the next value of every registered output.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = '0;
    wdata_d  = '0;
    mode_d   = '0;
    signed_d = signed_q;
    read_d   = 1'b0;
    write_d  = 1'b0;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    fault_d  = 1'b0;
    rdata_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.cpuReq) begin
          ready_d = 1'b0;
          if (misaligned(bus.cpuMode, bus.cpuAddr[1:0])) begin
            state_d = S_FAULT;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            state_d  = S_REQ;
            cnt_d    = '0;
            addr_d   = bus.cpuAddr;
            wdata_d  = bus.cpuWData;
            mode_d   = bus.cpuMode;
            signed_d = bus.cpuSigned;
            read_d   = ~bus.cpuWrite;
            write_d  = bus.cpuWrite;
          end
        end
      end

      S_REQ: begin
        if (bus.memReady) begin
          // memReady takes priority over a timeout that expires in the same cycle.
          state_d = S_RESP;
          done_d  = 1'b1;
          if (read_q) begin
            rdata_d = extend_load(bus.memReadData, mode_q, signed_q);
          end
        end else if (cnt_inc == CNT_LIMIT) begin
          state_d = S_FAULT;
          cnt_d   = cnt_inc;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else begin
          cnt_d   = cnt_inc;
          addr_d  = addr_q;
          wdata_d = wdata_q;
          mode_d  = mode_q;
          read_d  = read_q;
          write_d = write_q;
        end
      end

      S_RESP, S_FAULT: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State register and registered outputs; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register here samples pre-edge values.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mode_q   <= '0;
      signed_q <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mode_q   <= mode_d;
      signed_q <= signed_d;
      read_q   <= read_d;
      write_q  <= write_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.cpuReady     = ready_q;
  assign bus.cpuDone      = done_q;
  assign bus.cpuFault     = fault_q;
  assign bus.cpuRData     = rdata_q;
  assign bus.memAddr      = addr_q;
  assign bus.memWriteData = wdata_q;
  assign bus.memMode      = mode_q;
  assign bus.memRead      = read_q;
  assign bus.memWrite     = write_q;

endmodule
